// File: rtl/ipf_conv3x3_array.sv
// 3x3 convolution over a 3-row sliding window against up to NUM_K stored kernels, one LANES-wide beat per kernel.
// Result latency 1 cycle after issue; res_valid held until res_ready, stalled beats block further issue.
module ipf_conv3x3_array #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int NUM_K  = 4,
  parameter int ACC_W  = 2*DATA_W+4,
  localparam int KW    = (NUM_K > 1) ? $clog2(NUM_K) : 1,
  localparam int CW    = $clog2(NUM_K+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               ctrl,
  input  logic [9*DATA_W-1:0]      w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [LANES*DATA_W-1:0]  i_data,
  input  logic                     i_valid,
  output logic                     i_ready,
  output logic [LANES*ACC_W-1:0]   res,
  output logic [KW-1:0]            res_k,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     finish
);

  typedef enum logic [1:0] {ST_WAIT, ST_COMPUTE, ST_FINISH} state_t;

  state_t                  state, state_nxt;
  logic [9*DATA_W-1:0]     kmem [NUM_K];
  logic [CW-1:0]           kcnt;
  logic [KW-1:0]           kidx;
  logic [1:0]              rcnt;
  logic [LANES*DATA_W-1:0] row0, row1, row2;
  logic [LANES*DATA_W-1:0] win [3];
  logic [9*DATA_W-1:0]     kern;
  logic [LANES*ACC_W-1:0]  sum_all;

  logic ctrl_end, ctrl_start, ctrl_hold;
  logic win_full, last_k, issue, hold_clr, w_fire, i_fire;

  assign ctrl_end   = (ctrl == 2'd0);
  assign ctrl_start = (ctrl == 2'd1);
  assign ctrl_hold  = (ctrl == 2'd2);

  assign win_full = (rcnt == 2'd3);
  assign last_k   = (CW'(kidx) == kcnt - CW'(1));
  assign issue    = (state == ST_COMPUTE) && win_full && (!res_valid || res_ready)
                    && !ctrl_hold && !ctrl_end;
  assign hold_clr = (state == ST_COMPUTE) && ctrl_hold;
  assign w_fire   = w_valid && w_ready;
  assign i_fire   = i_valid && i_ready;
  assign finish   = (state == ST_FINISH);

  // In COMPUTE a row is taken on the last issue of a window, or whenever the
  // window has run dry, otherwise issuing could never resume.
  always_comb begin
    w_ready = (state == ST_WAIT) && (kcnt < CW'(NUM_K));
    i_ready = 1'b0;
    case (state)
      ST_WAIT:    i_ready = !win_full;
      ST_COMPUTE: i_ready = (issue && last_k) || (!win_full && !ctrl_hold && !ctrl_end);
      default:    i_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:    if (ctrl_start && (kcnt != '0) && win_full) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (ctrl_hold) state_nxt = ST_WAIT;
      default:    state_nxt = ST_FINISH;
    endcase
    if (ctrl_end) state_nxt = ST_FINISH;
  end

  always_comb begin
    win[0] = row0;
    win[1] = row1;
    win[2] = row2;
  end

  assign kern = kmem[kidx];

  // Column index wraps around the row so every lane sees a full 3-wide neighbourhood.
  always_comb begin
    sum_all = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          sum_all[j*ACC_W +: ACC_W] = sum_all[j*ACC_W +: ACC_W]
            + ACC_W'(kern[(3*r+c)*DATA_W +: DATA_W])
            * ACC_W'(win[r][((j+c)%LANES)*DATA_W +: DATA_W]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) kmem[KW'(kcnt)] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_WAIT;
      kcnt      <= '0;
      kidx      <= '0;
      rcnt      <= '0;
      row0      <= '0;
      row1      <= '0;
      row2      <= '0;
      res       <= '0;
      res_k     <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_clr) begin
        kcnt <= '0;
        rcnt <= '0;
        kidx <= '0;
      end else begin
        if (w_fire) kcnt <= kcnt + 1'b1;
        if (i_fire) begin
          row0 <= row1;
          row1 <= row2;
          row2 <= i_data;
          if (!win_full) rcnt <= rcnt + 2'd1;
        end else if (issue && last_k) begin
          rcnt <= 2'd2;
        end
        if (issue) kidx <= last_k ? '0 : kidx + 1'b1;
      end
      if (ctrl_end) begin
        res_valid <= 1'b0;
      end else if (issue) begin
        res       <= sum_all;
        res_k     <= kidx;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ipf_conv3x3_array.sv
// Bench for ipf_conv3x3_array: table of single-kernel windows plus hand sequences for stalls, HOLD, END and reset.
module tb_ipf_conv3x3_array;

  localparam int DW    = 8;
  localparam int L     = 8;
  localparam int NK    = 4;
  localparam int AW    = 2*DW+4;
  localparam int KW    = 2;
  localparam int RW    = L*DW;
  localparam int KBITS = 9*DW;
  localparam int RESW  = L*AW;
  localparam logic [1:0] C_END = 2'd0, C_START = 2'd1, C_HOLD = 2'd2, C_NOP = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ctrl;
  logic [KBITS-1:0] w_data;
  logic             w_valid, w_ready;
  logic [RW-1:0]    i_data;
  logic             i_valid, i_ready;
  logic [RESW-1:0]  res;
  logic [KW-1:0]    res_k;
  logic             res_valid, res_ready, finish;

  always #5 clk = ~clk;

  ipf_conv3x3_array #(.DATA_W(DW), .LANES(L), .NUM_K(NK)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .res(res), .res_k(res_k), .res_valid(res_valid), .res_ready(res_ready),
    .finish(finish)
  );

  typedef struct { logic [RESW-1:0] res; logic [KW-1:0] k; } beat_t;
  typedef struct { logic [KBITS-1:0] kern; logic [RW-1:0] r0, r1, r2; logic [RESW-1:0] exp; } vec_t;

  beat_t            sb[$];
  beat_t            mon_e;
  int               beat_cyc[$];
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  vec_t             vecs[4];
  logic [KBITS-1:0] ka, kb, kk;
  logic [KBITS-1:0] k4[4];
  logic [RW-1:0]    ra, rb, rc, rd;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RESW-1:0] ref_conv(input logic [KBITS-1:0] k,
                                               input logic [RW-1:0] a, b, c);
    logic [RW-1:0] rows [3];
    int acc;
    ref_conv = '0;
    rows[0] = a; rows[1] = b; rows[2] = c;
    for (int j = 0; j < L; j++) begin
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int col = 0; col < 3; col++)
          acc += int'(k[(3*r+col)*DW +: DW]) * int'(rows[r][((j+col)%L)*DW +: DW]);
      ref_conv[j*AW +: AW] = AW'(acc);
    end
  endfunction

  function automatic logic [KBITS-1:0] rand_kern();
    for (int t = 0; t < 9; t++) rand_kern[t*DW +: DW] = DW'($urandom_range(0, 255));
  endfunction

  function automatic logic [RW-1:0] rand_row();
    for (int p = 0; p < L; p++) rand_row[p*DW +: DW] = DW'($urandom_range(0, 255));
  endfunction

  task automatic chk(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [RESW-1:0] r, input int k);
    beat_t b;
    b.res = r;
    b.k   = KW'(k);
    sb.push_back(b);
  endtask

  task automatic send_kernel(input logic [KBITS-1:0] k);
    logic took;
    took = 1'b0;
    w_data  = k;
    w_valid = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = w_ready;
      tick();
    end
    w_valid = 1'b0;
    if (!took) begin
      checks++; failures++;
      $display("FAIL kernel_accept: w_ready stayed 0, expected 1");
    end
  endtask

  task automatic send_row(input logic [RW-1:0] r);
    logic took;
    took = 1'b0;
    i_data  = r;
    i_valid = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = i_ready;
      tick();
    end
    i_valid = 1'b0;
    if (!took) begin
      checks++; failures++;
      $display("FAIL row_accept: i_ready stayed 0, expected 1");
    end
  endtask

  task automatic do_ctrl(input logic [1:0] v);
    ctrl = v;
    tick();
    ctrl = C_NOP;
  endtask

  task automatic wait_vld(input string name);
    for (int n = 0; n < 30 && !res_valid; n++) tick();
    chk(name, res_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d beats still outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctrl = C_NOP; w_valid = 1'b0; i_valid = 1'b0; res_ready = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load3(input logic [RW-1:0] a, b, c);
    send_row(a);
    send_row(b);
    send_row(c);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got k=%0d res=%0h, expected no beat", res_k, res);
      end else begin
        mon_e = sb.pop_front();
        if (res !== mon_e.res || res_k !== mon_e.k) begin
          failures++;
          $display("FAIL beat: got k=%0d res=%0h, expected k=%0d res=%0h", res_k, res, mon_e.k, mon_e.res);
        end
      end
      beat_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    ctrl = C_NOP; w_data = '0; w_valid = 1'b0; i_data = '0; i_valid = 1'b0;
    res_ready = 1'b1; rst = 1'b0;

    vecs[0].kern = {9{8'h01}};
    vecs[0].r0   = 64'h0706050403020100;
    vecs[0].r1   = 64'h0706050403020100;
    vecs[0].r2   = 64'h0706050403020100;
    vecs[0].exp  = {20'd24, 20'd39, 20'd54, 20'd45, 20'd36, 20'd27, 20'd18, 20'd9};
    vecs[1].kern = {9{8'hFF}};
    vecs[1].r0   = {8{8'hFF}};
    vecs[1].r1   = {8{8'hFF}};
    vecs[1].r2   = {8{8'hFF}};
    vecs[1].exp  = {8{20'd585225}};
    vecs[2].kern = rand_kern();
    vecs[2].r0   = rand_row();
    vecs[2].r1   = rand_row();
    vecs[2].r2   = rand_row();
    vecs[2].exp  = ref_conv(vecs[2].kern, vecs[2].r0, vecs[2].r1, vecs[2].r2);
    kk = '0;
    kk[7*DW +: DW] = 8'd3;
    vecs[3].kern = kk;
    vecs[3].r0   = rand_row();
    vecs[3].r1   = rand_row();
    vecs[3].r2   = 64'h11100F0E0D0C0B0A;
    vecs[3].exp  = {20'd30, 20'd51, 20'd48, 20'd45, 20'd42, 20'd39, 20'd36, 20'd33};

    do_reset();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_finish", finish, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_i_ready", i_ready, 1);
    chk("rst_res", res, 0);
    chk("rst_res_k", res_k, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      send_kernel(vecs[v].kern);
      load3(vecs[v].r0, vecs[v].r1, vecs[v].r2);
      push(vecs[v].exp, 0);
      do_ctrl(C_START);
      wait_drain($sformatf("vec%0d_drain", v));
    end

    // two kernels under back-pressure, then a stall until the next row
    do_reset();
    ka = rand_kern(); kb = rand_kern();
    ra = rand_row(); rb = rand_row(); rc = rand_row(); rd = rand_row();
    send_kernel(ka);
    send_kernel(kb);
    load3(ra, rb, rc);
    res_ready = 1'b0;
    push(ref_conv(ka, ra, rb, rc), 0);
    push(ref_conv(kb, ra, rb, rc), 1);
    do_ctrl(C_START);
    wait_vld("bp_first_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_stable", res, ref_conv(ka, ra, rb, rc));
      chk("bp_res_k_stable", res_k, 0);
      chk("bp_valid_held", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    wait_drain("bp_drain");
    repeat (4) tick();
    chk("stall_no_issue", res_valid, 0);
    push(ref_conv(ka, rb, rc, rd), 0);
    push(ref_conv(kb, rb, rc, rd), 1);
    send_row(rd);
    wait_drain("next_window_drain");

    // row accepted on the last issue keeps the stream gapless
    do_reset();
    ra = rand_row(); rb = rand_row(); rc = rand_row(); rd = rand_row();
    send_kernel(ka);
    send_kernel(kb);
    load3(ra, rb, rc);
    beat_cyc.delete();
    push(ref_conv(ka, ra, rb, rc), 0);
    push(ref_conv(kb, ra, rb, rc), 1);
    push(ref_conv(ka, rb, rc, rd), 0);
    push(ref_conv(kb, rb, rc, rd), 1);
    fork
      send_row(rd);
      do_ctrl(C_START);
    join
    wait_drain("nobubble_drain");
    chk("nobubble_count", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) chk("nobubble_span", beat_cyc[3] - beat_cyc[0], 3);

    // all kernel slots full: extra kernel beats are refused
    do_reset();
    for (int i = 0; i < NK; i++) begin
      k4[i] = rand_kern();
      send_kernel(k4[i]);
    end
    chk("full_w_ready", w_ready, 0);
    w_data  = rand_kern();
    w_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("full_w_refused", w_ready, 0);
    end
    w_valid = 1'b0;
    ra = rand_row(); rb = rand_row(); rc = rand_row();
    load3(ra, rb, rc);
    for (int i = 0; i < NK; i++) push(ref_conv(k4[i], ra, rb, rc), i);
    do_ctrl(C_START);
    wait_drain("full_drain");

    // HOLD keeps the pending beat and flushes weights/window
    do_reset();
    ra = rand_row(); rb = rand_row(); rc = rand_row();
    send_kernel(ka);
    send_kernel(kb);
    load3(ra, rb, rc);
    res_ready = 1'b0;
    push(ref_conv(ka, ra, rb, rc), 0);
    do_ctrl(C_START);
    wait_vld("hold_first_valid");
    do_ctrl(C_HOLD);
    chk("hold_pending", res_valid, 1);
    chk("hold_res_k", res_k, 0);
    chk("hold_w_ready", w_ready, 1);
    chk("hold_i_ready", i_ready, 1);
    res_ready = 1'b1;
    wait_drain("hold_drain");
    tick();
    chk("hold_after_drain", res_valid, 0);
    do_ctrl(C_START);
    repeat (3) tick();
    chk("start_ignored_w_ready", w_ready, 1);
    chk("start_ignored_valid", res_valid, 0);

    // END drops the pending beat and locks the block
    send_kernel(kb);
    load3(rc, rb, ra);
    res_ready = 1'b0;
    do_ctrl(C_START);
    wait_vld("end_first_valid");
    do_ctrl(C_END);
    chk("end_finish", finish, 1);
    chk("end_res_valid", res_valid, 0);
    chk("end_w_ready", w_ready, 0);
    chk("end_i_ready", i_ready, 0);
    res_ready = 1'b1;
    repeat (5) tick();
    chk("end_finish_sticky", finish, 1);
    chk("end_no_beat", res_valid, 0);
    do_ctrl(C_START);
    chk("end_start_ignored", finish, 1);

    // asynchronous reset out of FINISH and out of a stalled compute
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_finish", finish, 0);
    chk("arst_w_ready", w_ready, 1);
    chk("arst_i_ready", i_ready, 1);
    tick();
    rst = 1'b0;
    send_kernel(ka);
    load3(ra, rb, rc);
    res_ready = 1'b0;
    do_ctrl(C_START);
    wait_vld("arst_mid_valid");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_mid_res_valid", res_valid, 0);
    chk("arst_mid_res", res, 0);
    chk("arst_mid_res_k", res_k, 0);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (4) tick();
    chk("arst_mid_quiet", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
